// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-high segment
// encodings for hex digits and the scan-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Element n is the pattern for nibble n; seg[0]=a ... seg[6]=g.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder, active-high output.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed, double-buffered 7-segment driver clocked by clk100mhz.
// Optional digit blinking is built only when SEG7_SCAN_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk100mhz,
  input  logic                  rst_n,
  input  logic                  scan_clk,
  input  logic                  blink_clk,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int              IW      = idx_w(DIGITS);
  localparam logic [IW-1:0]   LAST    = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_INV = {DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0]      SEG_INV = {7{SEG_ACTIVE_LOW != 0}};

  logic [2:0]          scan_sync_q, scan_sync_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                fd_q, fd_d;
  logic                pending_q, pending_d;
  logic                ready_q, ready_d;
  logic [4*DIGITS-1:0] pnd_data_q, pnd_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   pnd_dp_q, pnd_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   pnd_blank_q, pnd_blank_d, act_blank_q, act_blank_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                scan_tick, wrap, accept, lit;
  logic [3:0]          cur_nib;
  logic [6:0]          cur_seg;

`ifdef SEG7_SCAN_BLINK_EN
  logic [1:0]          blink_sync_q, blink_sync_d;
  logic [DIGITS-1:0]   pnd_mask_q, pnd_mask_d, act_mask_q, act_mask_d;
  logic                blink_on;
  assign blink_on = blink_sync_q[1];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_clk, blink_mask};
`endif

  // [0] and [1] form the synchroniser; [2] is the previous value for edge detect.
  assign scan_tick = scan_sync_q[1] & ~scan_sync_q[2];
  assign wrap      = scan_tick && (idx_q == LAST);
  assign accept    = load_valid && ready_q;
  assign cur_nib   = act_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (.nib(cur_nib), .seg(cur_seg));

  always_comb begin
    scan_sync_d = {scan_sync_q[1:0], scan_clk};
    idx_d       = idx_q;
    fd_d        = wrap;
    pending_d   = pending_q;
    pnd_data_d  = pnd_data_q;
    pnd_dp_d    = pnd_dp_q;
    pnd_blank_d = pnd_blank_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
`ifdef SEG7_SCAN_BLINK_EN
    blink_sync_d = {blink_sync_q[0], blink_clk};
    pnd_mask_d   = pnd_mask_q;
    act_mask_d   = act_mask_q;
`endif
    if (scan_tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    // accept and commit are mutually exclusive since ready is low while pending
    if (accept) begin
      pnd_data_d  = load_data;
      pnd_dp_d    = load_dp;
      pnd_blank_d = load_blank;
`ifdef SEG7_SCAN_BLINK_EN
      pnd_mask_d  = blink_mask;
`endif
      pending_d   = 1'b1;
    end else if (wrap && pending_q) begin
      act_data_d  = pnd_data_q;
      act_dp_d    = pnd_dp_q;
      act_blank_d = pnd_blank_q;
`ifdef SEG7_SCAN_BLINK_EN
      act_mask_d  = pnd_mask_q;
`endif
      pending_d   = 1'b0;
    end
    ready_d = !pending_d;

    lit = !act_blank_q[idx_q];
`ifdef SEG7_SCAN_BLINK_EN
    if (!blink_on && act_mask_q[idx_q]) lit = 1'b0;
`endif
    an_d  = (lit ? ({{(DIGITS-1){1'b0}}, 1'b1} << idx_q) : '0) ^ AN_INV;
    seg_d = (lit ? cur_seg : SEG_OFF) ^ SEG_INV;
    dp_d  = (lit & act_dp_q[idx_q]) ^ SEG_INV[0];
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      scan_sync_q <= '0;
      idx_q       <= '0;
      fd_q        <= 1'b0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b1;
      pnd_data_q  <= '0;
      pnd_dp_q    <= '0;
      pnd_blank_q <= '1;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      an_q        <= AN_INV;
      seg_q       <= SEG_OFF ^ SEG_INV;
      dp_q        <= SEG_INV[0];
`ifdef SEG7_SCAN_BLINK_EN
      blink_sync_q <= '0;
      pnd_mask_q   <= '0;
      act_mask_q   <= '0;
`endif
    end else begin
      scan_sync_q <= scan_sync_d;
      idx_q       <= idx_d;
      fd_q        <= fd_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      pnd_data_q  <= pnd_data_d;
      pnd_dp_q    <= pnd_dp_d;
      pnd_blank_q <= pnd_blank_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
`ifdef SEG7_SCAN_BLINK_EN
      blink_sync_q <= blink_sync_d;
      pnd_mask_q   <= pnd_mask_d;
      act_mask_q   <= act_mask_d;
`endif
    end
  end

  assign load_ready = ready_q;
  assign frame_done = fd_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: reset state, frame commit, held
// handshake, blanking, blink and mid-scan reset, sampled slot by slot.
module tb_seg7_scan_driver;

  logic        clk100mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_clk = 1'b0;
  logic        blink_clk = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic [7:0]  load_dp = '0;
  logic [7:0]  load_blank = '0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int since = 0;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_driver dut (
    .clk100mhz(clk100mhz), .rst_n(rst_n), .scan_clk(scan_clk),
    .blink_clk(blink_clk), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .load_blank(load_blank),
    .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk100mhz = ~clk100mhz;

  // 40-cycle scan period: one digit slot per 40 clocks
  always begin
    repeat (20) @(posedge clk100mhz);
    scan_clk = ~scan_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk100mhz);
    since += n;
  endtask

  task automatic goto(input int t);
    if (t > since) step(t - since);
  endtask

  task automatic wait_fd();
    int n = 0;
    @(negedge clk100mhz);
    while (!frame_done && n < 1000) begin
      @(negedge clk100mhz);
      n++;
    end
    chk("fd_seen", {31'b0, frame_done}, 32'd1);
    since = 0;
  endtask

  // Slot k (mod 8) of the frame that began at the last observed frame_done.
  task automatic check_slot(input string tag, input int k, input logic [31:0] d,
                            input logic [7:0] dpv, input logic [7:0] blank);
    int s;
    logic [7:0] ea;
    logic [3:0] nib;
    s = k % 8;
    goto(40 * k + 20);
    if (blank[s]) begin
      chk({tag, "_an"},  {24'b0, an},  32'hFF);
      chk({tag, "_seg"}, {25'b0, seg}, 32'h7F);
      chk({tag, "_dp"},  {31'b0, dp},  32'd1);
    end else begin
      ea  = 8'h01 << s;
      nib = d[4*s +: 4];
      chk({tag, "_an"},  {24'b0, an},  {24'b0, ~ea});
      chk({tag, "_seg"}, {25'b0, seg}, {25'b0, ~HEX[nib]});
      chk({tag, "_dp"},  {31'b0, dp},  {31'b0, ~dpv[s]});
    end
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dpv,
                      input logic [7:0] blank, input logic [7:0] mask);
    load_data  = d;
    load_dp    = dpv;
    load_blank = blank;
    blink_mask = mask;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    chk("ready_drop", {31'b0, load_ready}, 32'd0);
  endtask

  initial begin
    logic [7:0] bmask;
    step(3);
    chk("rst_an",    {24'b0, an},  32'hFF);
    chk("rst_seg",   {25'b0, seg}, 32'h7F);
    chk("rst_dp",    {31'b0, dp},  32'd1);
    chk("rst_ready", {31'b0, load_ready}, 32'd1);
    chk("rst_fd",    {31'b0, frame_done}, 32'd0);
    rst_n = 1'b1;

    wait_fd();
    check_slot("idle", 2, 32'h0, 8'h00, 8'hFF);

    // frame A commits at the next wrap
    wait_fd();
    step(5);
    load(32'h76543210, 8'h08, 8'h00, 8'h00);
    wait_fd();
    chk("ready_back", {31'b0, load_ready}, 32'd1);
    for (int k = 0; k < 8; k++) check_slot("frmA", k, 32'h76543210, 8'h08, 8'h00);

    // B pending while C is held on the bus; A must stay intact all frame
    wait_fd();
    step(5);
    load(32'hFEDCBA98, 8'h00, 8'h00, 8'h00);
    load_data  = 32'h89ABCDEF;
    load_dp    = 8'hF0;
    load_blank = 8'h0F;
    load_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_slot("holdA", k, 32'h76543210, 8'h08, 8'h00);
      chk("ready_hold", {31'b0, load_ready}, 32'd0);
    end
    wait_fd();
    chk("ready_commit", {31'b0, load_ready}, 32'd1);
    step(1);
    load_valid = 1'b0;
    chk("c_accept", {31'b0, load_ready}, 32'd0);
    for (int k = 0; k < 8; k++) check_slot("frmB", k, 32'hFEDCBA98, 8'h00, 8'h00);

    wait_fd();
    check_slot("frmC0", 0, 32'h89ABCDEF, 8'hF0, 8'h0F);
    check_slot("frmC3", 3, 32'h89ABCDEF, 8'hF0, 8'h0F);
    check_slot("frmC4", 4, 32'h89ABCDEF, 8'hF0, 8'h0F);
    check_slot("frmC7", 7, 32'h89ABCDEF, 8'hF0, 8'h0F);

    // blink on digit 0
    blink_clk = 1'b0;
    load(32'h76543210, 8'h00, 8'h00, 8'h01);
    wait_fd();
`ifdef SEG7_SCAN_BLINK_EN
    bmask = 8'h01;
`else
    bmask = 8'h00;
`endif
    check_slot("blink_lo0", 0, 32'h76543210, 8'h00, bmask);
    check_slot("blink_lo1", 1, 32'h76543210, 8'h00, 8'h00);
    blink_clk = 1'b1;
    check_slot("blink_hi0", 8, 32'h76543210, 8'h00, 8'h00);

    // reset during slot 5 with frame E pending
    wait_fd();
    step(5);
    load(32'hAAAAAAAA, 8'hFF, 8'h00, 8'h00);
    goto(40 * 5 + 20);
    rst_n = 1'b0;
    #1;
    chk("mrst_an",    {24'b0, an},  32'hFF);
    chk("mrst_seg",   {25'b0, seg}, 32'h7F);
    chk("mrst_dp",    {31'b0, dp},  32'd1);
    chk("mrst_ready", {31'b0, load_ready}, 32'd1);
    chk("mrst_fd",    {31'b0, frame_done}, 32'd0);
    step(3);
    rst_n = 1'b1;
    wait_fd();
    check_slot("noE0", 0, 32'hAAAAAAAA, 8'hFF, 8'hFF);
    check_slot("noE5", 5, 32'hAAAAAAAA, 8'hFF, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed 7-segment display driver. It sits directly downstream of the clock divider and consumes its slow outputs (scan rate and blink rate) as plain input levels.
- Runs entirely in the clk100mhz domain. Divided signals are synchronised and edge-detected into single-cycle enables and are never used as clocks.
- Holds a double-buffered frame of hex digits. New frames are loaded via a valid/ready handshake and committed only at a frame boundary, so the display never tears.

Parameters:
- DIGITS, 8: number of multiplexed digits (2..8).
- SEG_ACTIVE_LOW, 1: 1 drives seg/dp low for "lit".
- AN_ACTIVE_LOW, 1: 1 drives an low for "digit selected".

Ports:
- clk100mhz  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- scan_clk  in  1  scan-rate square wave from the divider (nominal 190 Hz); asynchronous to use.
- blink_clk  in  1  blink-rate square wave from the divider (nominal 3 Hz).
- load_valid  in  1  new frame offered.
- load_ready  out  1  driver can accept a frame.
- load_data  in  4*DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
- load_dp  in  DIGITS  decimal point per digit.
- load_blank  in  DIGITS  1 = digit dark.
- blink_mask  in  DIGITS  1 = digit blinks (sampled with the frame).
- an  out  DIGITS  digit enables, one-hot (or none).
- seg  out  7  segments; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point.
- frame_done  out  1  one-cycle pulse when the scan wraps.

Behaviour:
- Reset (async assert, sync-free release) values:
  - idx=0, pending empty, load_ready=1, frame_done=0.
  - Active buffer: data=0, blank=all 1, mask=0.
  - an = all inactive; seg and dp = all unlit.
- Synchronisers: scan_clk and blink_clk each pass through a 2-flop synchroniser.
  - scan_tick = 1-cycle pulse on the synchronised scan_clk rising edge.
  - blink_on = synchronised blink_clk level.
- Scan counter: idx advances by 1 on scan_tick. At idx==DIGITS-1 it wraps to 0, and frame_done pulses in the same cycle idx is written to 0.
- Handshake: a frame is accepted when load_valid && load_ready.
  - On accept: data/dp/blank/mask are captured into the pending buffer, pending is set, and load_ready drops the next cycle.
  - load_ready is registered and equals !pending.
- Commit: on a wrap cycle with pending=1, pending copies into the active buffer and pending clears. load_ready returns to 1 the cycle after the commit.
  - An accept can never coincide with a commit, because ready=0 while pending.
  - A frame accepted in the wrap cycle itself (pending was empty) waits for the next wrap.
- Output stage: registered, 1-cycle latency from the idx update.
  - an selects digit idx.
  - seg = hex decode of the active nibble; dp = active dp bit.
  - A digit with blank=1 outputs an all inactive, seg/dp unlit for its slot.
- Polarity: the SEG_ACTIVE_LOW and AN_ACTIVE_LOW inversions are applied only at the output registers.
- Mid-operation reset: everything returns to reset values immediately; any pending frame is discarded.
- Stall: scan_clk stuck means idx holds, the display freezes on one digit, and no frame_done fires.

Optional Feature:
- Macro: SEG7_SCAN_BLINK_EN.
- Defined: when blink_on==0 and the active mask[idx]==1, the digit is treated as blanked for that slot. Blink phase is not frame-aligned.
- Undefined: blink_clk and blink_mask are ignored and no blink logic is synthesised. Ports are kept so the interface is identical.

Decomposition:
- Package seg7_pkg holds:
  - Segment encodings for 0–F in active-high form, e.g. 0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F, F = 7'h71.
  - SEG_OFF = 7'h00.
  - The idx width function (clog2 of DIGITS).
- Sub-module seg7_hex_decode: purely combinational nibble-to-segment decoder, instantiated once on the selected nibble.

Test Plan:
- Reset, then drive scan_clk with period 40 cycles → an=8'hFF, seg=7'h7F, dp=1 throughout (defaults 1/1); load_ready=1.
- Load data 32'h76543210, blank 0, dp 0 → the next frame_done commits the frame. In the following frame, slot 0 gives an=8'hFE, seg=~7'h3F, and slot 3 gives an=8'hF7, seg=~7'h4F.
- Hold load_valid with a second frame while pending → load_ready stays 0 until the cycle after the commit. The second frame is never visible mid-frame; check every slot within a frame.
- load_blank=8'h0F → during slots 0–3, an=8'hFF and seg unlit; slots 4–7 are lit.
- With SEG7_SCAN_BLINK_EN, set blink_mask=8'h01 and toggle blink_clk → digit 0 is dark only while blink_clk is low; without the macro it is always lit.
- Assert rst_n low mid-scan at idx=5 with a frame pending → outputs are unlit immediately, idx=0, load_ready=1, and the pending frame never appears.
